// File: rtl/ddr_wr_serializer_pkg.sv
// Shared definitions for the DDR write serializer: FSM encoding, DQS patterns
// and parameter sanity helpers.
package ddr_wr_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_t;

    // DQS {d0, d1} patterns: the strobe toggles only while data is on the bus.
    localparam logic [1:0] DQS_PRE  = 2'b00;
    localparam logic [1:0] DQS_POST = 2'b00;
    localparam logic [1:0] DQS_DATA = 2'b10;

    function automatic bit burst_len_ok(input int bl);
        return (bl >= 2) && ((bl % 2) == 0);
    endfunction

    function automatic int cnt_width(input int pairs);
        return (pairs > 1) ? $clog2(pairs) : 1;
    endfunction

endpackage

// File: rtl/ddr_wr_serializer_beat_shifter.sv
// Load/shift register that presents the next rising/falling beat pair and masks.
// On load the pair comes straight from the incoming word so no cycle is lost.
module ddr_beat_shifter #(
    parameter int DQ_WIDTH  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic                          pop,
    input  logic [DQ_WIDTH*BURST_LEN-1:0] load_data,
    input  logic [BURST_LEN-1:0]          load_mask,
    output logic [DQ_WIDTH-1:0]           beat0,
    output logic [DQ_WIDTH-1:0]           beat1,
    output logic                          mask0,
    output logic                          mask1
);

    localparam int WORD_W = DQ_WIDTH * BURST_LEN;

    logic [WORD_W-1:0]    data_q, data_d, src_data;
    logic [BURST_LEN-1:0] mask_q, mask_d, src_mask;

    always_comb begin
        src_data = load ? load_data : data_q;
        src_mask = load ? load_mask : mask_q;
        beat0    = src_data[DQ_WIDTH-1:0];
        beat1    = src_data[2*DQ_WIDTH-1:DQ_WIDTH];
        mask0    = src_mask[0];
        mask1    = src_mask[1];
        data_d   = pop ? (src_data >> (2 * DQ_WIDTH)) : src_data;
        mask_d   = pop ? (src_mask >> 2) : src_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/ddr_wr_serializer.sv
// Write-path serializer: one burst word per handshake, sliced into D0/D1 beat
// pairs for the DQ/DM/DQS DDR output registers, with DQS pre/postamble.
module ddr_wr_serializer
    import ddr_wr_serializer_pkg::*;
#(
    parameter int DQ_WIDTH  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DQ_WIDTH*BURST_LEN-1:0] in_data,
    input  logic [BURST_LEN-1:0]          in_mask,
    output logic                          in_ready,
    output logic [DQ_WIDTH-1:0]           dq_d0,
    output logic [DQ_WIDTH-1:0]           dq_d1,
    output logic                          dm_d0,
    output logic                          dm_d1,
    output logic                          dqs_d0,
    output logic                          dqs_d1,
    output logic                          dq_oe,
    output logic                          dqs_oe,
    output logic                          burst_done
);

    localparam int               PAIRS = BURST_LEN / 2;
    localparam int               CNT_W = cnt_width(PAIRS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PAIRS - 1);

    if (!burst_len_ok(BURST_LEN)) begin : g_bad_burst_len
        $error("ddr_wr_serializer: BURST_LEN must be even and >= 2");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DQ_WIDTH-1:0] dq_d0_q, dq_d0_d, dq_d1_q, dq_d1_d;
    logic                dm_d0_q, dm_d0_d, dm_d1_q, dm_d1_d;
    logic                dqs_d0_q, dqs_d0_d, dqs_d1_q, dqs_d1_d;
    logic                dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d;
    logic                burst_done_q, burst_done_d;

    logic                accept, load, pop;
    logic [DQ_WIDTH-1:0] sh_beat0, sh_beat1;
    logic                sh_mask0, sh_mask1;

    // Handshake: a word moves on a rising edge with in_valid && in_ready.
    // in_ready depends only on state/counter (and reset), never on in_valid.
    assign in_ready = reset && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DATA) && (cnt_q == LAST)));
    assign accept   = in_valid && in_ready;

    ddr_beat_shifter #(
        .DQ_WIDTH  (DQ_WIDTH),
        .BURST_LEN (BURST_LEN)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load),
        .pop       (pop),
        .load_data (in_data),
        .load_mask (in_mask),
        .beat0     (sh_beat0),
        .beat1     (sh_beat1),
        .mask0     (sh_mask0),
        .mask1     (sh_mask1)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load         = 1'b0;
        pop          = 1'b0;
        dq_d0_d      = '0;
        dq_d1_d      = '0;
        dm_d0_d      = 1'b0;
        dm_d1_d      = 1'b0;
        dqs_d0_d     = 1'b0;
        dqs_d1_d     = 1'b0;
        dq_oe_d      = 1'b0;
        dqs_oe_d     = 1'b0;
        burst_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d              = ST_PRE;
                    load                 = 1'b1;
                    dqs_oe_d             = 1'b1;
                    {dqs_d0_d, dqs_d1_d} = DQS_PRE;
                end
            end
            ST_PRE: begin
                state_d = ST_DATA;
                cnt_d   = '0;
                pop     = 1'b1;
            end
            ST_DATA: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + 1'b1;
                    pop   = 1'b1;
                end else if (accept) begin
                    // Back-to-back burst: first pair of the new word follows directly.
                    cnt_d = '0;
                    load  = 1'b1;
                    pop   = 1'b1;
                end else begin
                    state_d              = ST_POST;
                    dqs_oe_d             = 1'b1;
                    {dqs_d0_d, dqs_d1_d} = DQS_POST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            dq_oe_d              = 1'b1;
            dqs_oe_d             = 1'b1;
            {dqs_d0_d, dqs_d1_d} = DQS_DATA;
            dq_d0_d              = sh_beat0;
            dq_d1_d              = sh_beat1;
            dm_d0_d              = sh_mask0;
            dm_d1_d              = sh_mask1;
            burst_done_d         = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dq_d0_q      <= '0;
            dq_d1_q      <= '0;
            dm_d0_q      <= 1'b0;
            dm_d1_q      <= 1'b0;
            dqs_d0_q     <= 1'b0;
            dqs_d1_q     <= 1'b0;
            dq_oe_q      <= 1'b0;
            dqs_oe_q     <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dq_d0_q      <= dq_d0_d;
            dq_d1_q      <= dq_d1_d;
            dm_d0_q      <= dm_d0_d;
            dm_d1_q      <= dm_d1_d;
            dqs_d0_q     <= dqs_d0_d;
            dqs_d1_q     <= dqs_d1_d;
            dq_oe_q      <= dq_oe_d;
            dqs_oe_q     <= dqs_oe_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign dq_d0      = dq_d0_q;
    assign dq_d1      = dq_d1_q;
    assign dm_d0      = dm_d0_q;
    assign dm_d1      = dm_d1_q;
    assign dqs_d0     = dqs_d0_q;
    assign dqs_d1     = dqs_d1_q;
    assign dq_oe      = dq_oe_q;
    assign dqs_oe     = dqs_oe_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_ddr_wr_serializer.sv
// Bench for ddr_wr_serializer: BURST_LEN=4 and BURST_LEN=8 instances checked
// cycle by cycle against a trace model built from the burst/handshake rules.
module tb_ddr_wr_serializer;

    localparam int W     = 8;
    localparam int BL_A  = 4;
    localparam int BL_B  = 8;
    localparam int PAIRS = BL_A / 2;

    // Observed tuple: {in_ready, burst_done, dq_oe, dqs_oe, dqs_d0, dqs_d1, dm_d0, dm_d1, dq_d1, dq_d0}
    localparam logic [23:0] IDLE_V = 24'h800000;
    localparam logic [23:0] PRE_V  = 24'h100000;
    localparam logic [23:0] POST_V = 24'h100000;

    logic clk = 1'b0;
    logic reset;

    logic            in_valid;
    logic [W*BL_A-1:0] in_data;
    logic [BL_A-1:0] in_mask;
    logic            in_ready;
    logic [W-1:0]    dq_d0, dq_d1;
    logic            dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe, dqs_oe, burst_done;

    logic            b_valid;
    logic [W*BL_B-1:0] b_data;
    logic [BL_B-1:0] b_mask;
    logic            b_ready;
    logic [W-1:0]    b_dq_d0, b_dq_d1;
    logic            b_dm_d0, b_dm_d1, b_dqs_d0, b_dqs_d1, b_dq_oe, b_dqs_oe, b_done;

    logic [23:0] act_a, act_b;
    logic [23:0] exp_q[$];
    logic [23:0] act_q[$];

    logic [31:0] w_data[8];
    logic [3:0]  w_mask[8];
    bit          w_bb[8];
    int          w_gap[8];
    int          rel[8];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr_wr_serializer #(.DQ_WIDTH(W), .BURST_LEN(BL_A)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_mask(in_mask), .in_ready(in_ready), .dq_d0(dq_d0), .dq_d1(dq_d1),
        .dm_d0(dm_d0), .dm_d1(dm_d1), .dqs_d0(dqs_d0), .dqs_d1(dqs_d1),
        .dq_oe(dq_oe), .dqs_oe(dqs_oe), .burst_done(burst_done)
    );

    ddr_wr_serializer #(.DQ_WIDTH(W), .BURST_LEN(BL_B)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data),
        .in_mask(b_mask), .in_ready(b_ready), .dq_d0(b_dq_d0), .dq_d1(b_dq_d1),
        .dm_d0(b_dm_d0), .dm_d1(b_dm_d1), .dqs_d0(b_dqs_d0), .dqs_d1(b_dqs_d1),
        .dq_oe(b_dq_oe), .dqs_oe(b_dqs_oe), .burst_done(b_done)
    );

    assign act_a = {in_ready, burst_done, dq_oe, dqs_oe, dqs_d0, dqs_d1, dm_d0, dm_d1, dq_d1, dq_d0};
    assign act_b = {b_ready, b_done, b_dq_oe, b_dqs_oe, b_dqs_d0, b_dqs_d1, b_dm_d0, b_dm_d1, b_dq_d1, b_dq_d0};

    function automatic logic [23:0] data_v(input bit last, input logic m0, input logic m1,
                                           input logic [7:0] d1, input logic [7:0] d0);
        return {last, last, 1'b1, 1'b1, 1'b1, 1'b0, m0, m1, d1, d0};
    endfunction

    // Reference trace: idle cycles, one PRE per stream, BURST_LEN/2 pairs per word, POST at stream end.
    task automatic build_trace(input int n);
        logic [31:0] w;
        logic [3:0]  m;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 0 || !w_bb[i]) begin
                if (i > 0) exp_q.push_back(POST_V);
                for (int g = 0; g < w_gap[i]; g++) exp_q.push_back(IDLE_V);
                rel[i] = exp_q.size() - 1;
                exp_q.push_back(PRE_V);
            end else begin
                rel[i] = 0;
            end
            w = w_data[i];
            m = w_mask[i];
            for (int j = 0; j < PAIRS; j++)
                exp_q.push_back(data_v(j == PAIRS - 1, m[2*j], m[2*j+1], w[(2*j+1)*W +: W], w[2*j*W +: W]));
        end
        exp_q.push_back(POST_V);
        for (int k = 0; k < 3; k++) exp_q.push_back(IDLE_V);
    endtask

    // Driver: offers word idx from its release cycle on, holds it until in_ready.
    task automatic run_bursts(input int n);
        int idx;
        int total;
        build_trace(n);
        act_q.delete();
        idx   = 0;
        total = exp_q.size();
        for (int cyc = 0; cyc < total; cyc++) begin
            @(negedge clk);
            act_q.push_back(act_a);
            if (idx < n && cyc >= rel[idx]) begin
                in_valid = 1'b1;
                in_data  = w_data[idx];
                in_mask  = w_mask[idx];
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_mask  = 4'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        in_valid = 1'b0;
        b_valid  = 1'b0;
        in_data  = '0;
        in_mask  = '0;
        b_data   = '0;
        b_mask   = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_a !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_a got %h want %h", act_a, 24'h0);
        end
        n_checks++;
        if (act_b !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_b got %h want %h", act_b, 24'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (act_a !== IDLE_V) begin
            n_fail++;
            $display("FAIL post_reset_idle got %h want %h", act_a, IDLE_V);
        end
    endtask

    task automatic test_idle_quiet;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (act_a !== IDLE_V || act_b !== IDLE_V) begin
                n_fail++;
                $display("FAIL idle_quiet cyc%0d got %h/%h want %h", k, act_a, act_b, IDLE_V);
            end
        end
    endtask

    task automatic test_single;
        w_data[0] = 32'hDDCCBBAA;
        w_mask[0] = 4'b0100;
        w_bb[0]   = 1'b0;
        w_gap[0]  = 2;
        run_bursts(1);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL single cyc%0d got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        w_data[0] = 32'h44332211; w_mask[0] = 4'b0000; w_bb[0] = 1'b0; w_gap[0] = 1;
        w_data[1] = 32'h88776655; w_mask[1] = 4'b1001; w_bb[1] = 1'b1; w_gap[1] = 0;
        run_bursts(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_gap;
        w_data[0] = 32'hA1B2C3D4; w_mask[0] = 4'b0010; w_bb[0] = 1'b0; w_gap[0] = 1;
        w_data[1] = 32'h0F1E2D3C; w_mask[1] = 4'b1000; w_bb[1] = 1'b0; w_gap[1] = 1;
        run_bursts(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL gap cyc%0d got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random_stream;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                w_data[i] = $urandom;
                w_mask[i] = 4'($urandom_range(0, 15));
                w_bb[i]   = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                w_gap[i]  = $urandom_range(1, 3);
            end
            run_bursts(6);
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (act_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL random r%0d cyc%0d got %h want %h", r, k, act_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hCAFEF00D;
        in_mask  = 4'b1111;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (act_a !== data_v(1'b0, 1'b1, 1'b1, 8'hF0, 8'h0D)) begin
            n_fail++;
            $display("FAIL mid_burst_first_pair got %h want %h", act_a, data_v(1'b0, 1'b1, 1'b1, 8'hF0, 8'h0D));
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (act_a !== 24'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h want %h", act_a, 24'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (act_a !== IDLE_V) begin
                n_fail++;
                $display("FAIL after_reset cyc%0d got %h want %h", k, act_a, IDLE_V);
            end
        end
        w_data[0] = 32'h13572468; w_mask[0] = 4'b0110; w_bb[0] = 1'b0; w_gap[0] = 1;
        run_bursts(1);
        for (int k = 0; k < exp_q.size(); k++) begin
            n_checks++;
            if (act_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL after_reset_burst cyc%0d got %h want %h", k, act_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_burst8;
        logic [63:0]   d;
        logic [7:0]    m;
        logic [23:0]   e;
        d = 64'h0706050403020100;
        m = 8'($urandom);
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = d;
        b_mask  = m;
        @(negedge clk);
        b_valid = 1'b0;
        b_data  = $urandom;
        n_checks++;
        if (act_b !== PRE_V) begin
            n_fail++;
            $display("FAIL burst8_pre got %h want %h", act_b, PRE_V);
        end
        for (int j = 0; j < BL_B / 2; j++) begin
            @(negedge clk);
            e = data_v(j == BL_B / 2 - 1, m[2*j], m[2*j+1], d[(2*j+1)*W +: W], d[2*j*W +: W]);
            n_checks++;
            if (act_b !== e) begin
                n_fail++;
                $display("FAIL burst8_pair%0d got %h want %h", j, act_b, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (act_b !== POST_V) begin
            n_fail++;
            $display("FAIL burst8_post got %h want %h", act_b, POST_V);
        end
        @(negedge clk);
        n_checks++;
        if (act_b !== IDLE_V) begin
            n_fail++;
            $display("FAIL burst8_idle got %h want %h", act_b, IDLE_V);
        end
    endtask

    initial begin
        test_reset;
        test_idle_quiet;
        test_single;
        test_back_to_back;
        test_gap;
        test_random_stream;
        test_reset_mid_burst;
        test_burst8;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
